// File: rtl/csr_access_unit_if.sv
// Request, CSR-file and response signals shared by the CSR access sequencer and its pipeline/CSR-file side.
// The master side is the execute stage plus the CSR file; the slave side is csr_access_unit.
interface csr_access_unit_if #(
    parameter int DW = 32,
    parameter int AW = 14
);
    logic          ReqValid;
    logic          ReqReady;
    logic [1:0]    ReqOp;
    logic [AW-1:0] ReqAddr;
    logic [DW-1:0] ReqWData;
    logic [DW-1:0] ReqMask;
    logic          Flush;
    logic [AW-1:0] RAddr;
    logic [DW-1:0] RData;
    logic          WEn;
    logic [AW-1:0] WAddr;
    logic [DW-1:0] WDate;
    logic          RspValid;
    logic          RspReady;
    logic [DW-1:0] RspData;
    logic          RspErr;

    modport master (
        output ReqValid, ReqOp, ReqAddr, ReqWData, ReqMask, Flush, RData, RspReady,
        input  ReqReady, RAddr, WEn, WAddr, WDate, RspValid, RspData, RspErr
    );

    modport slave (
        input  ReqValid, ReqOp, ReqAddr, ReqWData, ReqMask, Flush, RData, RspReady,
        output ReqReady, RAddr, WEn, WAddr, WDate, RspValid, RspData, RspErr
    );
endinterface

// File: rtl/csr_access_unit.sv
// Sequencer for csrrd/csrwr/csrxchg: read old value, write new value once, return old value.
// Optional macro CSR_ADDR_CHECK_EN enables the implemented-address check and CPUID write protection.
module csr_access_unit #(
    parameter int DW = 32,
    parameter int AW = 14
) (
    input logic              Clk,
    input logic              Rest,
    csr_access_unit_if.slave bus
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    localparam logic [1:0] OP_RD   = 2'b00;
    localparam logic [1:0] OP_WR   = 2'b01;
    localparam logic [1:0] OP_XCHG = 2'b10;

    state_t        state_q, state_d;
    logic [1:0]    op_q, op_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] mask_q, mask_d;
    logic [DW-1:0] old_q, old_d;
    logic [DW-1:0] new_q, new_d;
    logic          err_q, err_d;

    logic          addr_ok;
    logic          wr_blocked;
    logic          is_write;
    logic          accept;

`ifdef CSR_ADDR_CHECK_EN
    function automatic logic addr_implemented(input logic [AW-1:0] a);
        return a inside {AW'('h0), AW'('h1), [AW'('h4):AW'('h7)], AW'('hC),
                         [AW'('h10):AW'('h13)], [AW'('h18):AW'('h1B)], AW'('h20),
                         [AW'('h30):AW'('h33)], [AW'('h40):AW'('h44)], AW'('h60),
                         AW'('h88), AW'('h180), AW'('h181)};
    endfunction

    assign addr_ok    = addr_implemented(addr_q);
    // CPUID is read-only: writes are dropped silently, not flagged as errors
    assign wr_blocked = (addr_q == AW'('h20));
`else
    assign addr_ok    = 1'b1;
    assign wr_blocked = 1'b0;
`endif

    assign is_write = (op_q == OP_WR) || (op_q == OP_XCHG);
    assign accept   = (state_q == IDLE) && bus.ReqValid && !bus.Flush;

    // State register
    always_ff @(posedge Clk or negedge Rest) begin
        if (!Rest) begin
            state_q <= IDLE;
            op_q    <= OP_RD;
            addr_q  <= '0;
            wdata_q <= '0;
            mask_q  <= '0;
            old_q   <= '0;
            new_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            mask_q  <= mask_d;
            old_q   <= old_d;
            new_q   <= new_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (accept) state_d = READ;
            READ: begin
                if (bus.Flush)
                    state_d = IDLE;
                else if (is_write && addr_ok && !wr_blocked)
                    state_d = WRITE;
                else
                    state_d = RESP;
            end
            WRITE: state_d = RESP;
            RESP:  if (bus.RspReady) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request capture and old/new value computation
    always_comb begin
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        mask_d  = mask_q;
        old_d   = old_q;
        new_d   = new_q;
        err_d   = err_q;
        if (accept) begin
            // reserved op 11 behaves as a plain read
            op_d    = (bus.ReqOp == 2'b11) ? OP_RD : bus.ReqOp;
            addr_d  = bus.ReqAddr;
            wdata_d = bus.ReqWData;
            mask_d  = bus.ReqMask;
        end
        if (state_q == READ) begin
            old_d = addr_ok ? bus.RData : '0;
            new_d = (op_q == OP_XCHG) ? ((wdata_q & mask_q) | (bus.RData & ~mask_q))
                                      : wdata_q;
            err_d = !addr_ok;
        end
    end

    // Output logic
    always_comb begin
        bus.ReqReady = 1'b0;
        bus.RAddr    = '0;
        bus.WEn      = 1'b0;
        bus.WAddr    = '0;
        bus.WDate    = '0;
        bus.RspValid = 1'b0;
        bus.RspData  = '0;
        bus.RspErr   = 1'b0;
        case (state_q)
            IDLE:  bus.ReqReady = Rest;
            READ:  bus.RAddr    = addr_q;
            WRITE: begin
                bus.WEn   = 1'b1;
                bus.WAddr = addr_q;
                bus.WDate = new_q;
            end
            RESP: begin
                bus.RspValid = 1'b1;
                bus.RspData  = old_q;
                bus.RspErr   = err_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_csr_access_unit.sv
// Scoreboard bench for csr_access_unit: driver pushes expected writes/responses, negedge monitor pops and compares.
// Expected values come from a CSR-file reference array updated by the request rules (honours CSR_ADDR_CHECK_EN).
module tb_csr_access_unit;

    localparam int DW = 32;
    localparam int AW = 14;
`ifdef CSR_ADDR_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic Clk = 1'b0;
    logic Rest = 1'b0;
    always #5 Clk = ~Clk;

    csr_access_unit_if #(.DW(DW), .AW(AW)) bus ();

    csr_access_unit #(.DW(DW), .AW(AW)) dut (
        .Clk  (Clk),
        .Rest (Rest),
        .bus  (bus)
    );

    // CSR file seen by the DUT, and the bench's own reference copy
    logic [DW-1:0] csr_file [0:(1<<AW)-1];
    logic [DW-1:0] ref_mem  [0:(1<<AW)-1];
    assign bus.RData = csr_file[bus.RAddr];
    always @(posedge Clk) if (bus.WEn) csr_file[bus.WAddr] <= bus.WDate;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          err;
        int            acc;
        int            lat;
    } rsp_t;
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            at;
    } wr_t;

    rsp_t rsp_q[$];
    wr_t  wr_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    localparam int NADDR = 22;
    localparam int ALIST [NADDR] = '{'h0, 'h1, 'h4, 'h7, 'hC, 'h10, 'h13, 'h18, 'h1B, 'h20, 'h30,
                                     'h33, 'h40, 'h44, 'h60, 'h88, 'h180, 'h181,
                                     'h2, 'h8, 'h100, 'h3FFF};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit implemented(input int a);
        return a inside {'h0, 'h1, ['h4:'h7], 'hC, ['h10:'h13], ['h18:'h1B], 'h20,
                         ['h30:'h33], ['h40:'h44], 'h60, 'h88, 'h180, 'h181};
    endfunction

    // fmode: 0 none, 1 flush in accept cycle, 2 flush in READ, 3 flush in WRITE
    task automatic issue(input logic [1:0] op, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wd, input logic [DW-1:0] mk,
                         input int fmode, input int stall);
        logic [1:0]    eop;
        bit            ok, wr;
        logic [DW-1:0] old_v, new_v;
        int            acc, n;
        eop   = (op == 2'b11) ? 2'b00 : op;
        ok    = !CHK || implemented(int'(addr));
        wr    = (eop != 2'b00) && ok && !(CHK && addr == AW'('h20));
        old_v = ok ? ref_mem[addr] : '0;
        new_v = (eop == 2'b10) ? ((wd & mk) | (old_v & ~mk)) : wd;

        bus.ReqValid = 1'b1;
        bus.ReqOp    = op;
        bus.ReqAddr  = addr;
        bus.ReqWData = wd;
        bus.ReqMask  = mk;
        bus.Flush    = (fmode == 1);
        @(posedge Clk); #1;
        bus.ReqValid = 1'b0;
        bus.Flush    = 1'b0;
        bus.ReqWData = $urandom;
        bus.ReqMask  = $urandom;
        bus.ReqAddr  = AW'($urandom);

        if (fmode == 1) begin
            check("flush_blocks_accept", bus.ReqReady, 1);
            return;
        end
        acc = cyc;
        if (fmode == 2) begin
            bus.Flush = 1'b1;
            @(posedge Clk); #1;
            bus.Flush = 1'b0;
            check("flush_read_idle", bus.ReqReady, 1);
            return;
        end

        if (wr) begin
            ref_mem[addr] = new_v;
            wr_q.push_back('{addr: addr, data: new_v, at: acc + 1});
        end
        rsp_q.push_back('{data: old_v, err: (CHK && !ok), acc: acc, lat: (wr ? 3 : 2)});

        n = 0;
        while (!bus.RspValid && n < 8) begin
            bus.Flush = (fmode == 3 && n == 1);
            @(posedge Clk); #1;
            n++;
        end
        bus.Flush = 1'b0;
        if (!bus.RspValid) begin
            n_tests++;
            n_fail++;
            $display("FAIL rsp_timeout: RspValid=0 required 1 after %0d cycles", n);
            return;
        end
        repeat (stall) begin @(posedge Clk); #1; end
        bus.RspReady = 1'b1;
        @(posedge Clk); #1;
        bus.RspReady = 1'b0;
    endtask

    // Monitor
    logic          prev_pend = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic          prev_err  = 1'b0;
    always @(negedge Clk) begin
        rsp_t e;
        wr_t  w;
        if (Rest) begin
            if (bus.RspValid) begin
                check("busy_reqready_rsp", bus.ReqReady, 0);
                if (prev_pend) begin
                    check("rsp_hold_data", bus.RspData, prev_data);
                    check("rsp_hold_err", bus.RspErr, prev_err);
                end else if (rsp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_rsp: data=0x%0h, required no response", bus.RspData);
                end else begin
                    e = rsp_q.pop_front();
                    check("rsp_data", bus.RspData, e.data);
                    check("rsp_err", bus.RspErr, e.err);
                    check("rsp_latency", cyc - e.acc + 1, e.lat);
                    $display("[TB] rsp data=0x%08h err=%0d lat=%0d", bus.RspData, bus.RspErr,
                             cyc - e.acc + 1);
                end
            end
            if (bus.WEn) begin
                check("busy_reqready_wr", bus.ReqReady, 0);
                if (wr_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_wen: addr=0x%0h, required no write", bus.WAddr);
                end else begin
                    w = wr_q.pop_front();
                    check("wr_addr", bus.WAddr, w.addr);
                    check("wr_data", bus.WDate, w.data);
                    check("wr_cycle", cyc, w.at);
                end
            end
        end
        prev_pend = bus.RspValid && !bus.RspReady;
        prev_data = bus.RspData;
        prev_err  = bus.RspErr;
    end

    initial begin
        logic [DW-1:0] v;
        bus.ReqValid = 1'b1;
        bus.ReqOp    = 2'b01;
        bus.ReqAddr  = AW'('h6);
        bus.ReqWData = $urandom;
        bus.ReqMask  = $urandom;
        bus.Flush    = 1'b0;
        bus.RspReady = 1'b0;
        for (int i = 0; i < (1 << AW); i++) begin
            v = $urandom;
            csr_file[i] <= v;
            ref_mem[i]   = v;
        end
        csr_file[14'h30] <= 32'hDEADBEEF;
        ref_mem[14'h30]   = 32'hDEADBEEF;
        csr_file[14'h0]  <= 32'h000000A8;
        ref_mem[14'h0]    = 32'h000000A8;

        repeat (3) begin
            @(negedge Clk);
            check("reset_reqready", bus.ReqReady, 0);
            check("reset_wen", bus.WEn, 0);
            check("reset_rspvalid", bus.RspValid, 0);
            check("reset_rspdata", bus.RspData, 0);
            check("reset_raddr", bus.RAddr, 0);
        end
        @(posedge Clk); #1;
        bus.ReqValid = 1'b0;
        Rest = 1'b1;
        #1;
        check("post_reset_reqready", bus.ReqReady, 1);

        issue(2'b00, AW'('h30), $urandom, $urandom, 0, 0);
        issue(2'b10, AW'('h0), 32'hFFFFFFFF, 32'h00000007, 0, 0);
        issue(2'b01, AW'('h6), 32'h12345678, $urandom, 0, 5);
        issue(2'b01, AW'('h12), 32'hCAFEF00D, $urandom, 2, 0);
        issue(2'b01, AW'('h12), 32'h0BADC0DE, $urandom, 3, 1);
        issue(2'b00, AW'('h12), $urandom, $urandom, 0, 0);
        issue(2'b01, AW'('h2), 32'h55AA55AA, $urandom, 0, 0);
        issue(2'b10, AW'('h20), $urandom, $urandom, 0, 0);
        issue(2'b00, AW'('h20), $urandom, $urandom, 0, 0);
        issue(2'b11, AW'('h44), $urandom, $urandom, 0, 2);
        issue(2'b01, AW'('h4), $urandom, $urandom, 1, 0);

        for (int t = 0; t < 200; t++) begin
            int r, fm;
            r  = $urandom_range(0, 9);
            fm = (r < 3) ? r + 1 : 0;
            issue(2'($urandom_range(0, 3)), AW'(ALIST[$urandom_range(0, NADDR - 1)]),
                  $urandom, $urandom, fm, $urandom_range(0, 3));
        end

        repeat (4) @(posedge Clk);
        #1;
        check("rsp_queue_drained", rsp_q.size(), 0);
        check("wr_queue_drained", wr_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/csr_access_unit.md
# csr_access_unit

Sequencer between the execute stage and the CSR register file for `csrrd`, `csrwr` and `csrxchg`. It accepts one request at a time on a valid/ready handshake. It reads the old CSR value through the file's read port, computes the new value, and issues a single-cycle write (`WEn`/`WAddr`/`WDate`) to the CSR file. It then returns the old value to the pipeline on a response handshake.

## Interface
Parameters:
- `DW`, 32: CSR data width (matches `DataBus`).
- `AW`, 14: CSR address width.

Ports:
- `Clk` in 1: the only clock; all state updates on its rising edge.
- `Rest` in 1: asynchronous, active-low reset.
- `ReqValid` in 1: request present.
- `ReqReady` out 1: unit can accept a request.
- `ReqOp` in 2: 00 RD, 01 WR, 10 XCHG, 11 reserved.
- `ReqAddr` in AW: CSR number.
- `ReqWData` in DW: new data (rd register value).
- `ReqMask` in DW: XCHG bit mask (rj value).
- `Flush` in 1: pipeline flush.
- `RAddr` out AW: CSR file read address.
- `RData` in DW: CSR file read data, combinational from `RAddr`.
- `WEn` out 1: CSR write enable.
- `WAddr` out AW: CSR write address.
- `WDate` out DW: CSR write data.
- `RspValid` out 1: response present.
- `RspReady` in 1: consumer accepts response.
- `RspData` out DW: CSR value before the write.
- `RspErr` out 1: access to an unimplemented CSR (see Configuration).

## Operation
States: IDLE, READ, WRITE, RESP.
- **IDLE:**
  - `ReqReady`=1.
  - On `ReqValid && ReqReady && !Flush`, capture op, addr, wdata and mask, then go to READ.
  - Op 11 is treated as RD.
- **READ:**
  - `RAddr` = captured address. In all other states `RAddr`=0.
  - At the clock edge, `RData` is latched into `OldReg`.
  - New value: WR gives wdata; XCHG gives `(wdata & mask) | (RData & ~mask)`.
  - If `Flush` is asserted: go to IDLE with no write and no response.
  - Else, if op is WR or XCHG and the write is permitted: go to WRITE.
  - Otherwise: go to RESP.
- **WRITE:**
  - `WEn`=1 for exactly this one cycle, with `WAddr`/`WDate` from registers.
  - `Flush` is ignored (the write commits).
  - Next state is RESP.
- **RESP:**
  - `RspValid`=1, `RspData`=`OldReg`, `RspErr` registered.
  - Holds until `RspReady`, then goes to IDLE. `Flush` is ignored.
- **Outputs outside their active states:** `WEn`=0, `RspValid`=0, `RspData`=0, `WAddr`=0, `WDate`=0.
- **Reset** (asynchronous, `Rest`=0):
  - State goes to IDLE and every register clears.
  - While `Rest`=0, `ReqReady`=0, `WEn`=0, `RspValid`=0, `RspData`=0, `RspErr`=0 and `RAddr`=0.
- **Reset mid-operation:** a pending write or response is discarded.

## Timing
- Request accepted at edge E0.
- RD: `RspValid` rises after E1 (2-cycle latency).
- WR/XCHG: `WEn` is high in cycle E1–E2, and `RspValid` rises after E2 (3-cycle latency).
- Response is held stable while `RspValid && !RspReady`.
- Next request is accepted no earlier than the cycle after the response handshake. `ReqReady` is low in READ, WRITE and RESP.
- `RspData` always returns the pre-write value, even for XCHG to the same CSR.
- `Flush` in the accept cycle blocks acceptance. In READ it aborts. Later it has no effect.

## Configuration
`CSR_ADDR_CHECK_EN`
- **Defined:**
  - Addresses are checked against the implemented set: 0x0, 0x1, 0x4–0x7, 0xC, 0x10–0x13, 0x18–0x1B, 0x20, 0x30–0x33, 0x40–0x44, 0x60, 0x88, 0x180, 0x181.
  - Unimplemented address: `OldReg` forced to 0, no write issued, `RspErr`=1.
  - Write or XCHG to 0x20 (CPUID): write suppressed, `RspErr`=0.
- **Undefined:**
  - All addresses pass and writes to 0x20 are issued.
  - `RspErr` is tied to 0.

## Test plan
- Reset held low for 3 cycles with `ReqValid`=1 → `ReqReady`=0, `WEn`=0, `RspValid`=0. After release, `ReqReady`=1.
- RD to 0x30 with the file returning 0xDEADBEEF → no `WEn`; `RspValid` 2 cycles after accept with `RspData`=0xDEADBEEF.
- XCHG to 0x0 with old value 0x000000A8, wdata 0xFFFFFFFF, mask 0x00000007 → one `WEn` pulse with `WAddr`=0x0 and `WDate`=0x000000AF; `RspData`=0x000000A8 at latency 3.
- WR to 0x6 with `RspReady` held low for 5 cycles → exactly one `WEn`; `RspValid` and `RspData` stable for all 5 cycles; `ReqReady`=0 until the handshake completes.
- WR to 0x12 with `Flush` in the READ cycle → no `WEn`, no `RspValid`, back in IDLE. `Flush` asserted in the WRITE cycle instead → write still issued and response still delivered.
- With `CSR_ADDR_CHECK_EN` defined, WR to 0x2 → no `WEn`, `RspData`=0, `RspErr`=1. Without the macro, `WEn` pulses with `WAddr`=0x2 and `RspErr`=0.
